// File: rtl/program_loader_if.sv
// ============================================================================
// Module      : program_loader_if
// Description : Byte-stream handshake and instruction-memory write bundle
//               between the boot stream source and program_loader.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface program_loader_if;
    logic        start;
    logic [7:0]  RXData;
    logic        RXValid;
    logic        RXReady;
    logic        IMWrEn;
    logic [31:0] IMWrAddr;
    logic [31:0] IMWrData;
    logic        CPUHold;
    logic        Busy;
    logic        Done;
    logic        Error;
    logic [15:0] WordCount;

    modport master (
        output start, RXData, RXValid,
        input  RXReady, IMWrEn, IMWrAddr, IMWrData,
        input  CPUHold, Busy, Done, Error, WordCount
    );

    modport slave (
        input  start, RXData, RXValid,
        output RXReady, IMWrEn, IMWrAddr, IMWrData,
        output CPUHold, Busy, Done, Error, WordCount
    );
endinterface

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module      : program_loader
// Description : Assembles a length-prefixed little-endian byte stream into
//               32-bit words, writes them to instruction memory and holds
//               the CPU in reset until a complete image is loaded.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module program_loader #(
    parameter int unsigned DEPTH = 1024,
    parameter logic [31:0] BASE  = 32'h0000_0000
) (
    input  wire logic        CLK,
    input  wire logic        reset,
    program_loader_if.slave  bus
);

    localparam int unsigned c_idx_w = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN0  = 3'd1,
        S_LEN1  = 3'd2,
        S_LOAD  = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t               r_state;
    logic [15:0]          r_len;
    logic [c_idx_w-1:0]   r_word_idx;
    logic [1:0]           r_byte_idx;
    logic [23:0]          r_asm;
    logic                 r_rx_ready;
    logic                 r_wr_en;
    logic [31:0]          r_wr_addr;
    logic [31:0]          r_wr_data;
    logic                 r_cpu_hold;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;
    logic [15:0]          r_word_count;

    state_t               w_next;
    logic                 w_xfer;
    logic [15:0]          w_len;
    logic                 w_last;
    logic                 w_next_busy;

    always_comb begin
        w_xfer = bus.RXValid & r_rx_ready;
        w_len  = {bus.RXData, r_len[7:0]};
        w_last = ((32'(r_word_idx) + 32'd1) == 32'(r_len));
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (bus.start) w_next = S_LEN0;
            end
            S_LEN0: begin
                if (w_xfer) w_next = S_LEN1;
            end
            S_LEN1: begin
                if (w_xfer) begin
                    if (w_len == 16'd0)              w_next = S_DONE;
                    else if (32'(w_len) > DEPTH)     w_next = S_ERROR;
                    else                             w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_xfer && (r_byte_idx == 2'd3) && w_last) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
        w_next_busy = (w_next == S_LEN0) || (w_next == S_LEN1) || (w_next == S_LOAD);
    end

    // Status outputs are decoded from the next state so they line up with the
    // state register; CPUHold alone drops one cycle into DONE so the final
    // write has already landed before the processor leaves reset.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_len        <= 16'd0;
            r_word_idx   <= '0;
            r_byte_idx   <= 2'd0;
            r_asm        <= 24'd0;
            r_rx_ready   <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= 32'd0;
            r_wr_data    <= 32'd0;
            r_cpu_hold   <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_word_count <= 16'd0;
        end else begin
            r_state    <= w_next;
            r_rx_ready <= w_next_busy;
            r_busy     <= w_next_busy;
            r_done     <= (w_next == S_DONE);
            r_error    <= (w_next == S_ERROR);
            r_cpu_hold <= !((r_state == S_DONE) && (w_next == S_DONE));
            r_wr_en    <= 1'b0;

            case (r_state)
                S_LEN0: begin
                    if (w_xfer) r_len[7:0] <= bus.RXData;
                end
                S_LEN1: begin
                    if (w_xfer) begin
                        r_len[15:8]  <= bus.RXData;
                        r_word_count <= w_len;
                        r_word_idx   <= '0;
                        r_byte_idx   <= 2'd0;
                    end
                end
                S_LOAD: begin
                    if (w_xfer) begin
                        r_asm      <= {bus.RXData, r_asm[23:8]};
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_wr_en    <= 1'b1;
                            r_wr_data  <= {bus.RXData, r_asm};
                            r_wr_addr  <= BASE + (32'(r_word_idx) << 2);
                            r_word_idx <= r_word_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.RXReady   = r_rx_ready;
    assign bus.IMWrEn    = r_wr_en;
    assign bus.IMWrAddr  = r_wr_addr;
    assign bus.IMWrData  = r_wr_data;
    assign bus.CPUHold   = r_cpu_hold;
    assign bus.Busy      = r_busy;
    assign bus.Done      = r_done;
    assign bus.Error     = r_error;
    assign bus.WordCount = r_word_count;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module      : tb_program_loader
// Description : Self-checking bench for program_loader: vector table,
//               randomized loads against a write-queue model, corner cases.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_program_loader;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic CLK;
    logic reset;
    program_loader_if bus();

    program_loader #(.DEPTH(DEPTH), .BASE(BASE)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int wr_count = 0;
    logic [63:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every write is matched in order against the image the bench streamed.
    always @(negedge CLK) begin
        if (bus.IMWrEn) begin
            wr_count++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr %h data %h expected none",
                         bus.IMWrAddr, bus.IMWrData);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({bus.IMWrAddr, bus.IMWrData} !== e) begin
                    fails++;
                    $display("FAIL write: got %h/%h expected %h/%h",
                             bus.IMWrAddr, bus.IMWrData, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit inj);
        int n;
        for (int k = 0; k < 3 && gap > 0 && $urandom_range(99) < gap; k++) begin
            bus.RXValid = 1'b0;
            bus.RXData  = 8'($urandom);
            @(negedge CLK);
        end
        bus.RXValid = 1'b1;
        bus.RXData  = b;
        bus.start   = inj && ($urandom_range(7) == 0);
        n = 0;
        while (!bus.RXReady && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL rx_ready_timeout: got 0 expected 1");
        end
        @(negedge CLK);
        bus.RXValid = 1'b0;
        bus.start   = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, input bit inj);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap, inj);
    endtask

    // Model: a header of N<=DEPTH loads N words at BASE+4i; otherwise nothing.
    task automatic run_load(input logic [15:0] n, input int gap, input bit inj);
        logic [31:0] w;
        pulse_start();
        send_byte(n[7:0], gap, inj);
        send_byte(n[15:8], gap, inj);
        if (n != 16'd0 && 32'(n) <= DEPTH) begin
            for (int i = 0; i < int'(n); i++) begin
                w = $urandom;
                exp_q.push_back({BASE + 32'(4 * i), w});
                send_word(w, gap, inj);
            end
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic check_end(input string tag, input bit e_done, input bit e_err,
                             input logic [15:0] e_wc, input int e_writes, input int wr0);
        chk({tag, "_done"},    32'(bus.Done),      32'(e_done));
        chk({tag, "_error"},   32'(bus.Error),     32'(e_err));
        chk({tag, "_hold"},    32'(bus.CPUHold),   32'(!e_done));
        chk({tag, "_rxready"}, 32'(bus.RXReady),   32'd0);
        chk({tag, "_busy"},    32'(bus.Busy),      32'd0);
        chk({tag, "_wc"},      32'(bus.WordCount), 32'(e_wc));
        chk({tag, "_writes"},  32'(wr_count - wr0), 32'(e_writes));
        chk({tag, "_pending"}, 32'(exp_q.size()),  32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rxready"}, 32'(bus.RXReady),   32'd0);
        chk({tag, "_wren"},    32'(bus.IMWrEn),    32'd0);
        chk({tag, "_addr"},    bus.IMWrAddr,       32'd0);
        chk({tag, "_data"},    bus.IMWrData,       32'd0);
        chk({tag, "_hold"},    32'(bus.CPUHold),   32'd1);
        chk({tag, "_busy"},    32'(bus.Busy),      32'd0);
        chk({tag, "_done"},    32'(bus.Done),      32'd0);
        chk({tag, "_error"},   32'(bus.Error),     32'd0);
        chk({tag, "_wc"},      32'(bus.WordCount), 32'd0);
    endtask

    typedef struct {
        logic [15:0] n;
        int          gap;
        bit          inj;
        bit          e_done;
        bit          e_err;
        int          e_writes;
    } vec_t;

    vec_t tbl[7];
    logic [7:0] plan[10];

    initial begin
        int wr0;
        logic [15:0] rn;

        tbl[0] = '{16'd2,     0,  0, 1'b1, 1'b0, 2};
        tbl[1] = '{16'd3,     40, 1, 1'b1, 1'b0, 3};
        tbl[2] = '{16'd1025,  30, 0, 1'b0, 1'b1, 0};
        tbl[3] = '{16'd1,     50, 1, 1'b1, 1'b0, 1};
        tbl[4] = '{16'd0,     0,  0, 1'b1, 1'b0, 0};
        tbl[5] = '{16'd1024,  0,  0, 1'b1, 1'b0, 1024};
        tbl[6] = '{16'd65535, 20, 1, 1'b0, 1'b1, 0};
        plan = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};

        bus.start   = 1'b0;
        bus.RXValid = 1'b0;
        bus.RXData  = 8'h00;
        reset       = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_vals("reset");
        reset = 1'b1;
        repeat (2) @(negedge CLK);
        check_reset_vals("idle");

        // Reference image back-to-back, with exact write and hold timing.
        wr0 = wr_count;
        exp_q.push_back({32'h0000_0000, 32'h0010_0513});
        exp_q.push_back({32'h0000_0004, 32'h0020_0593});
        pulse_start();
        chk("len0_rxready", 32'(bus.RXReady), 32'd1);
        chk("len0_busy",    32'(bus.Busy),    32'd1);
        foreach (plan[i]) send_byte(plan[i], 0, 0);
        chk("final_wren",   32'(bus.IMWrEn),  32'd1);
        chk("final_done",   32'(bus.Done),    32'd1);
        chk("final_hold",   32'(bus.CPUHold), 32'd1);
        @(negedge CLK);
        chk("after_wren",   32'(bus.IMWrEn),  32'd0);
        chk("after_hold",   32'(bus.CPUHold), 32'd0);
        @(negedge CLK);
        check_end("plan", 1'b1, 1'b0, 16'd2, 2, wr0);

        // Same image with RXValid gaps.
        wr0 = wr_count;
        exp_q.push_back({32'h0000_0000, 32'h0010_0513});
        exp_q.push_back({32'h0000_0004, 32'h0020_0593});
        pulse_start();
        foreach (plan[i]) send_byte(plan[i], 60, 0);
        repeat (2) @(negedge CLK);
        check_end("plan_gaps", 1'b1, 1'b0, 16'd2, 2, wr0);

        // Empty image: Done two cycles into the load, no writes.
        wr0 = wr_count;
        pulse_start();
        send_byte(8'h00, 0, 0);
        chk("n0_busy_len1", 32'(bus.Busy), 32'd1);
        send_byte(8'h00, 0, 0);
        chk("n0_done",      32'(bus.Done),    32'd1);
        chk("n0_hold_edge", 32'(bus.CPUHold), 32'd1);
        @(negedge CLK);
        check_end("n0", 1'b1, 1'b0, 16'd0, 0, wr0);

        // Vector table; entry 3 also clears the Error left by entry 2.
        foreach (tbl[i]) begin
            wr0 = wr_count;
            run_load(tbl[i].n, tbl[i].gap, tbl[i].inj);
            check_end($sformatf("tbl%0d", i), tbl[i].e_done, tbl[i].e_err,
                      tbl[i].n, tbl[i].e_writes, wr0);
        end

        // Reset after 5 payload bytes of a 2-word load.
        pulse_start();
        exp_q.push_back({BASE, 32'hA1B2_C3D4});
        exp_q.push_back({BASE + 32'd4, 32'h5566_7788});
        send_byte(8'h02, 0, 0);
        send_byte(8'h00, 0, 0);
        send_word(32'hA1B2_C3D4, 0, 0);
        send_byte(8'h88, 0, 0);
        reset = 1'b0;
        #1;
        check_reset_vals("abort");
        chk("abort_pending", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        wr0 = wr_count;
        run_load(16'd2, 0, 0);
        check_end("reload", 1'b1, 1'b0, 16'd2, 2, wr0);

        // Randomized loads with gaps and stray start pulses during the load.
        for (int r = 0; r < 8; r++) begin
            rn  = 16'($urandom_range(1, 6));
            wr0 = wr_count;
            run_load(rn, int'($urandom_range(0, 70)), 1);
            check_end($sformatf("rand%0d", r), 1'b1, 1'b0, rn, int'(rn), wr0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/program_loader.md
# program_loader

Boot-time program loader sitting directly upstream of the single-cycle processor's instruction memory. It accepts a byte stream (typically from a UART receiver) over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes each word into the instruction memory's write port at consecutive word addresses. While loading, it holds the processor in reset, and it releases the processor only after a complete, well-formed image has been written.

## Interface
Parameters:
- DEPTH, 1024: instruction memory capacity in 32-bit words; largest accepted image.
- BASE, 32'h0000_0000: byte address of the first word written.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  one-cycle pulse; begins a new load from IDLE, DONE or ERROR; ignored while busy.
- RXData  in  8  incoming byte.
- RXValid  in  1  RXData is valid.
- RXReady  out  1  loader accepts a byte this cycle.
- IMWrEn  out  1  instruction memory write strobe, one cycle per word.
- IMWrAddr  out  32  byte address of the word being written.
- IMWrData  out  32  assembled instruction word.
- CPUHold  out  1  1 = processor held in reset; 0 = processor runs.
- Busy  out  1  load in progress.
- Done  out  1  last load completed successfully.
- Error  out  1  last load rejected because the length exceeds DEPTH.
- WordCount  out  16  length N received in the current or last header.

## Operation
- Stream format:
  - 2 header bytes: N[7:0], then N[15:8].
  - Followed by 4*N payload bytes.
  - Within each word, the first byte goes to [7:0] and the fourth byte goes to [31:24].
- A byte is transferred only in a cycle where RXValid and RXReady are both 1. The loader never drops a transferred byte.
- FSM states: IDLE, LEN0, LEN1, LOAD, DONE, ERROR.
  - IDLE: RXReady=0, CPUHold=1. On start, go to LEN0.
  - LEN0: RXReady=1. On transfer, latch N[7:0] and go to LEN1.
  - LEN1: RXReady=1. On transfer, latch N[15:8], then:
    - If N==0, go to DONE.
    - Else if N>DEPTH, go to ERROR.
    - Otherwise go to LOAD with word index=0 and byte index=0.
  - LOAD: RXReady=1. Each transfer shifts the byte into the assembly register and increments the 2-bit byte index.
    - On the 4th byte, the registered write fires (IMWrEn=1 next cycle) with IMWrAddr=BASE+4*index and IMWrData=the assembled word; index then increments.
    - After word N-1 is written, go to DONE.
  - DONE: RXReady=0, CPUHold=0, Done=1. On start, go to LEN0 and reassert CPUHold.
  - ERROR: RXReady=0, CPUHold=1, Error=1, no memory writes. On start, go to LEN0 and clear Error.
- Busy=1 exactly in LEN0, LEN1 and LOAD.
- start arriving in LEN0, LEN1 or LOAD is ignored.
- Address arithmetic is 32-bit and wraps modulo 2^32. The index counter is wide enough for DEPTH with no overflow, because N<=DEPTH is enforced.

## Timing
- Reset values (asynchronous, immediate on reset=0):
  - State=IDLE.
  - RXReady=0, IMWrEn=0, IMWrAddr=0, IMWrData=0.
  - CPUHold=1, Busy=0, Done=0, Error=0, WordCount=0.
- Reset asserted mid-load aborts the load. Words already written stay in memory, but Done stays 0 and CPUHold stays 1.
- RXReady is a registered, state-decoded output. Throughput is one byte per cycle when RXValid is held high.
- Write latency: IMWrEn pulses exactly 1 cycle after the transfer of a word's 4th byte. It lasts 1 cycle and never overlaps a gap in the data.
- Final-word timing: DONE is entered in the same cycle the final IMWrEn is high. CPUHold falls 1 cycle after the final IMWrEn, so the last word is in memory before the processor leaves reset.
- N==0: DONE is entered the cycle after the LEN1 transfer. No IMWrEn occurs.
- A start pulse in DONE/ERROR moves to LEN0 the next cycle; RXReady=1 from then on.
- RXValid low stalls the FSM with no state change. Partial words are held indefinitely.

## Test plan
- Reset, then start, then stream 02 00 13 05 10 00 93 05 20 00 back-to-back:
  - IMWrEn pulses at address 0x0 with data 0x00100513, then at 0x4 with 0x00200593.
  - WordCount=2, Done=1, and CPUHold falls 1 cycle after the second write.
- Same stream with RXValid toggled randomly: identical writes, addresses and data. No byte is lost or duplicated.
- Header 01 04 (N=1025) with DEPTH=1024: Error=1, no IMWrEn, CPUHold stays 1, RXReady=0. A following start with a valid image succeeds and clears Error.
- Header 00 00: Done=1 two cycles after the start-driven load begins, with zero IMWrEn pulses and CPUHold=0.
- Assert reset after 5 payload bytes of a 2-word load: all outputs return to reset values immediately. Start plus a full reload then completes correctly.
- start pulsed during LOAD: ignored; the load completes normally with the correct word count and addresses.
